// File: rtl/mips32_issue_interlock.sv
// Issue interlock between fetch and ID for pipe_MIPS32: holds one fetched instruction and
// inserts NOP bubbles while any of its source registers matches a recently issued destination.
module mips32_issue_interlock #(
    parameter int unsigned HAZARD_WINDOW = 3,
    parameter logic [31:0] NOP_INSTR     = 32'h0ce77800,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_bubble,
    output logic [31:0]      out_instr,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    logic                                hold_valid_q;
    logic [31:0]                         hold_instr_q;
    logic [HAZARD_WINDOW-1:0]            sb_valid_q;
    logic [HAZARD_WINDOW-1:0][4:0]       sb_reg_q;
    logic                                out_valid_q;
    logic                                out_bubble_q;
    logic [31:0]                         out_instr_q;
    logic                                halted_q;
    logic [CNT_W-1:0]                    stall_count_q;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       src1_v, src2_v, dst_v;
    logic [4:0] dst;
    logic       hit, hazard, issue_now, accept;

    // Decode the held instruction into its register sources and destination.
    always_comb begin
        opcode = hold_instr_q[31:26];
        rs     = hold_instr_q[25:21];
        rt     = hold_instr_q[20:16];
        rd     = hold_instr_q[15:11];
        src1_v = 1'b0;
        src2_v = 1'b0;
        dst_v  = 1'b0;
        dst    = rd;
        if (opcode <= 6'b000101) begin
            src1_v = 1'b1;
            src2_v = 1'b1;
            dst_v  = 1'b1;
        end else if (opcode == 6'b001000 || (opcode >= 6'b001010 && opcode <= 6'b001100)) begin
            src1_v = 1'b1;
            dst_v  = 1'b1;
            dst    = rt;
        end else if (opcode == 6'b001001) begin
            src1_v = 1'b1;
            src2_v = 1'b1;
        end else if (opcode == 6'b001101 || opcode == 6'b001110) begin
            src1_v = 1'b1;
        end
        // R0 is hardwired, so it never carries a dependency.
        src1_v = src1_v & (rs != 5'd0);
        src2_v = src2_v & (rt != 5'd0);
        dst_v  = dst_v & (dst != 5'd0);
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(HAZARD_WINDOW); i++) begin
            if (sb_valid_q[i] && ((src1_v && sb_reg_q[i] == rs) || (src2_v && sb_reg_q[i] == rt)))
                hit = 1'b1;
        end
    end

    assign hazard    = hold_valid_q & hit;
    assign issue_now = hold_valid_q & ~hazard & ~halted_q & ~flush;
    assign in_ready  = ~halted_q & ~flush & (~hold_valid_q | issue_now);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q  <= 1'b0;
            hold_instr_q  <= 32'd0;
            sb_valid_q    <= '0;
            sb_reg_q      <= '0;
            out_valid_q   <= 1'b0;
            out_bubble_q  <= 1'b0;
            out_instr_q   <= NOP_INSTR;
            halted_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            // Only a real issue records a destination; bubbles, gaps and flushes age the window.
            for (int i = int'(HAZARD_WINDOW) - 1; i > 0; i--) begin
                sb_valid_q[i] <= sb_valid_q[i-1];
                sb_reg_q[i]   <= sb_reg_q[i-1];
            end
            sb_valid_q[0] <= issue_now & dst_v;
            sb_reg_q[0]   <= dst;

            if (flush) begin
                hold_valid_q <= 1'b0;
                out_valid_q  <= 1'b0;
                out_bubble_q <= 1'b0;
            end else if (issue_now) begin
                out_valid_q  <= 1'b1;
                out_bubble_q <= 1'b0;
                out_instr_q  <= hold_instr_q;
                hold_valid_q <= accept;
                if (accept) hold_instr_q <= in_instr;
                if (opcode == 6'b111111) halted_q <= 1'b1;
            end else if (hazard && !halted_q) begin
                out_valid_q  <= 1'b1;
                out_bubble_q <= 1'b1;
                out_instr_q  <= NOP_INSTR;
                if (stall_count_q != '1) stall_count_q <= stall_count_q + 1'b1;
            end else begin
                out_valid_q  <= 1'b0;
                out_bubble_q <= 1'b0;
                if (accept) begin
                    hold_valid_q <= 1'b1;
                    hold_instr_q <= in_instr;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bubble  = out_bubble_q;
    assign out_instr   = out_instr_q;
    assign halted      = halted_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_mips32_issue_interlock.sv
// Scenario bench for mips32_issue_interlock: expected issue slots are queued as stimulus is
// built and compared against the slots the DUT emits.
module tb_mips32_issue_interlock;

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0ce77800;
    localparam logic [31:0] HLT   = 32'hfc000000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      in_instr = 32'd0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_bubble;
    logic [31:0]      out_instr;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    mips32_issue_interlock #(
        .HAZARD_WINDOW(3),
        .NOP_INSTR    (NOP),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_bubble (out_bubble),
        .out_instr  (out_instr),
        .halted     (halted),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    logic [31:0] prog_q[$];
    logic [32:0] e, o;
    logic        acc;
    int          streak, max_streak, ready_low, ready_hi;

    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {6'b001010, rs, rt, imm};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] beqz(input logic [4:0] rs);
        return {6'b001110, rs, 5'd0, 16'd4};
    endfunction

    task automatic push_instr(input logic [31:0] i, input bit expect_issue);
        prog_q.push_back(i);
        if (expect_issue) exp_q.push_back({1'b0, i});
    endtask

    task automatic push_bubbles(input int n);
        repeat (n) exp_q.push_back({1'b1, NOP});
    endtask

    // One clock: sample outputs at the falling edge, then return 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (out_valid === 1'b1) begin
            obs_q.push_back({out_bubble, out_instr});
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else begin
            streak = 0;
        end
        acc = in_valid & in_ready;
        if (in_valid && !in_ready) ready_low++;
        if (in_ready) ready_hi++;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int drain);
        int idx = 0;
        int budget = 0;
        int total = prog_q.size();
        if (total > 0) begin
            in_valid = 1'b1;
            in_instr = prog_q[0];
        end
        while (idx < total && budget < 200) begin
            cycle();
            budget++;
            if (acc) begin
                idx++;
                if (idx < total) in_instr = prog_q[idx];
            end
        end
        in_valid = 1'b0;
        prog_q.delete();
        checks++;
        if (idx != total) begin
            errors++;
            $display("FAIL feed_accept: accepted %0d of %0d instructions", idx, total);
        end
        repeat (drain) cycle();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        streak = 0;
        max_streak = 0;
        ready_low = 0;
        ready_hi = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_bubble !== 1'b0) begin errors++;
            $display("FAIL reset_out_bubble: got %b, expected 0", out_bubble); end
        checks++; if (out_instr !== NOP) begin errors++;
            $display("FAIL reset_out_instr: got %h, expected %h", out_instr, NOP); end
        checks++; if (halted !== 1'b0) begin errors++;
            $display("FAIL reset_halted: got %b, expected 0", halted); end
        checks++; if (stall_count !== '0) begin errors++;
            $display("FAIL reset_stall_count: got %0d, expected 0", stall_count); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_raw_adjacent();
        do_reset();
        push_instr(addi(5'd1, 5'd0, 16'd10), 1'b1);
        push_bubbles(3);
        push_instr(add(5'd4, 5'd1, 5'd2), 1'b1);
        feed(8);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL adjacent_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin errors++;
                $display("FAIL adjacent_slot: got %h, expected %h", o, e); end
        end
        checks++; if (stall_count !== 4'd3) begin errors++;
            $display("FAIL adjacent_stall_count: got %0d, expected 3", stall_count); end
    endtask

    task automatic test_raw_distance();
        // ADD R4,R1,R2 depends on R2 two slots back and R1 three back: the nearer wins (2 bubbles).
        do_reset();
        push_instr(addi(5'd1, 5'd0, 16'd1), 1'b1);
        push_instr(addi(5'd2, 5'd0, 16'd2), 1'b1);
        push_instr(addi(5'd3, 5'd0, 16'd3), 1'b1);
        push_bubbles(2);
        push_instr(add(5'd4, 5'd1, 5'd2), 1'b1);
        feed(8);
        checks++; if (stall_count !== 4'd2) begin errors++;
            $display("FAIL distance2_stall_count: got %0d, expected 2", stall_count); end
        // Depending only on R1 (three slots back) costs a single bubble.
        push_instr(addi(5'd1, 5'd0, 16'd1), 1'b1);
        push_instr(addi(5'd2, 5'd0, 16'd2), 1'b1);
        push_instr(addi(5'd3, 5'd0, 16'd3), 1'b1);
        push_bubbles(1);
        push_instr(add(5'd4, 5'd1, 5'd1), 1'b1);
        feed(8);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL distance_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin errors++;
                $display("FAIL distance_slot: got %h, expected %h", o, e); end
        end
        checks++; if (stall_count !== 4'd3) begin errors++;
            $display("FAIL distance_stall_count: got %0d, expected 3", stall_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 1; n <= 8; n++) push_instr(addi(5'(n), 5'd0, 16'(n)), 1'b1);
        feed(4);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL stream_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin errors++;
                $display("FAIL stream_slot: got %h, expected %h", o, e); end
        end
        checks++; if (max_streak != 8) begin errors++;
            $display("FAIL stream_consecutive: got %0d, expected 8", max_streak); end
        checks++; if (ready_low != 0) begin errors++;
            $display("FAIL stream_in_ready: got %0d not-ready cycles, expected 0", ready_low); end
    endtask

    task automatic test_decode();
        // R0 writes/reads never stall; a branch reading a just-written register does.
        do_reset();
        push_instr(addi(5'd0, 5'd0, 16'd5), 1'b1);
        push_instr(add(5'd6, 5'd0, 5'd0), 1'b1);
        push_instr(add(5'd4, 5'd0, 5'd0), 1'b1);
        push_bubbles(3);
        push_instr(beqz(5'd4), 1'b1);
        feed(8);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL decode_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin errors++;
                $display("FAIL decode_slot: got %h, expected %h", o, e); end
        end
        checks++; if (stall_count !== 4'd3) begin errors++;
            $display("FAIL decode_stall_count: got %0d, expected 3", stall_count); end
    endtask

    task automatic test_flush();
        do_reset();
        push_instr(addi(5'd1, 5'd0, 16'd10), 1'b1);
        push_bubbles(1);
        push_instr(add(5'd4, 5'd1, 5'd2), 1'b0);
        feed(1);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL flush_in_ready: got %b, expected 0", in_ready); end
        cycle();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL flush_out_valid: got %b, expected 0", out_valid); end
        push_instr(addi(5'd6, 5'd0, 16'd1), 1'b1);
        feed(6);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL flush_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin errors++;
                $display("FAIL flush_slot: got %h, expected %h", o, e); end
        end
        checks++; if (stall_count !== 4'd1) begin errors++;
            $display("FAIL flush_stall_count: got %0d, expected 1", stall_count); end
    endtask

    task automatic test_halt();
        do_reset();
        push_instr(HLT, 1'b1);
        push_instr(add(5'd5, 5'd4, 5'd3), 1'b0);
        feed(3);
        checks++; if (halted !== 1'b1) begin errors++;
            $display("FAIL halt_halted: got %b, expected 1", halted); end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL halt_in_ready: got %b, expected 0", in_ready); end
        in_valid = 1'b1;
        in_instr = addi(5'd7, 5'd0, 16'd1);
        ready_hi = 0;
        repeat (6) cycle();
        in_valid = 1'b0;
        checks++; if (ready_hi != 0) begin errors++;
            $display("FAIL halt_ready_cycles: got %0d, expected 0", ready_hi); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL halt_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin errors++;
                $display("FAIL halt_slot: got %h, expected %h", o, e); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_instr(addi(5'd1, 5'd0, 16'd10), 1'b0);
        push_instr(add(5'd4, 5'd1, 5'd2), 1'b0);
        feed(1);
        checks++; if (out_bubble !== 1'b1) begin errors++;
            $display("FAIL midreset_pre_bubble: got %b, expected 1", out_bubble); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_bubble !== 1'b0 || out_instr !== NOP) begin errors++;
            $display("FAIL midreset_outputs: got v=%b b=%b i=%h, expected v=0 b=0 i=%h",
                     out_valid, out_bubble, out_instr, NOP); end
        checks++; if (stall_count !== '0 || halted !== 1'b0) begin errors++;
            $display("FAIL midreset_state: got cnt=%0d halted=%b, expected 0/0", stall_count, halted); end
        obs_q.delete();
        // With the scoreboard cleared, the first ADD sees no stale R1 entry.
        push_instr(add(5'd4, 5'd1, 5'd2), 1'b1);
        push_instr(addi(5'd1, 5'd0, 16'd10), 1'b1);
        push_bubbles(3);
        push_instr(add(5'd4, 5'd1, 5'd2), 1'b1);
        feed(8);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL midreset_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin errors++;
                $display("FAIL midreset_slot: got %h, expected %h", o, e); end
        end
        checks++; if (stall_count !== 4'd3) begin errors++;
            $display("FAIL midreset_stall_count: got %0d, expected 3", stall_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int p = 0; p < 6; p++) begin
            push_instr(addi(5'd1, 5'd0, 16'(p)), 1'b1);
            push_bubbles(3);
            push_instr(add(5'd4, 5'd1, 5'd2), 1'b1);
        end
        feed(8);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL saturate_slots: got %0d slots, expected %0d", obs_q.size(), exp_q.size()); end
        exp_q.delete();
        obs_q.delete();
        checks++; if (stall_count !== {CNT_W{1'b1}}) begin errors++;
            $display("FAIL saturate_stall_count: got %0d, expected %0d", stall_count, {CNT_W{1'b1}}); end
    endtask

    initial begin
        test_reset();
        test_raw_adjacent();
        test_raw_distance();
        test_back_to_back();
        test_decode();
        test_flush();
        test_halt();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
